alarm_controller: RTL and testbench

Alarm stage directly downstream of the seconds/minutes clock counter. It consumes the live `seconds`/`minutes` values, holds a programmable alarm time, and raises `ring` when the clock reaches that time. It provides snooze, stop and auto-timeout behaviour. It is the block that drives the buzzer/LED enable in the clock subsystem.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/sec_tick_detect.sv | 25 ++
 rtl/alarm_controller.sv | 153 +++++++++++++++
 tb/tb_alarm_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the clock subsystem stages.
// Imported by the alarm controller and the seconds tick detector.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;

  // True when a minutes/seconds pair is a legal wall-clock time.
  function automatic logic time_valid(input logic [5:0] m, input logic [5:0] s);
    return (m <= MAX_MIN) && (s <= MAX_SEC);
  endfunction

endpackage

// File: rtl/sec_tick_detect.sv
// Produces a one-cycle tick whenever the live seconds value changes.
// Reusable by any stage sitting behind the clock counter.
module sec_tick_detect
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  output logic       tick
);

  logic [5:0] sec_q_r;

  // Remember last cycle's seconds value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q_r <= 6'd0;
    end else begin
      sec_q_r <= seconds;
    end
  end

  assign tick = (seconds != sec_q_r);

endmodule

// File: rtl/alarm_controller.sv
// Alarm stage: stores an alarm time, rings on match, and handles
// snooze, stop, disarm and ring auto-timeout.
module alarm_controller
  import clock_pkg::*;
#(
  parameter int RING_SECS   = 10,
  parameter int SNOOZE_SECS = 5,
  parameter int MAX_SNOOZES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [5:0]   seconds,
  input  logic [5:0]   minutes,
  input  logic         arm_en,
  input  logic         set_valid,
  input  logic [5:0]   set_min,
  input  logic [5:0]   set_sec,
  input  logic         snooze_btn,
  input  logic         stop_btn,
  output logic         ring,
  output logic         snoozing,
  output alarm_state_t state,
  output logic [5:0]   alarm_min,
  output logic [5:0]   alarm_sec,
  output logic         set_err
);

  localparam int SNZ_W = $clog2(MAX_SNOOZES + 1);
  localparam logic [SNZ_W-1:0] SNZ_MAX  = SNZ_W'(MAX_SNOOZES);
  localparam logic [SNZ_W-1:0] SNZ_ONE  = SNZ_W'(1);
  localparam logic [5:0]       RING_LAST = 6'(RING_SECS - 1);
  localparam logic [5:0]       SNZ_LAST  = 6'(SNOOZE_SECS - 1);

  alarm_state_t     state_r, state_nx_s;
  logic [5:0]       ring_cnt_r, ring_cnt_nx_s;
  logic [5:0]       snz_cnt_r, snz_cnt_nx_s;
  logic [SNZ_W-1:0] snz_used_r, snz_used_nx_s;
  logic [5:0]       alarm_min_r, alarm_sec_r;
  logic             ring_r, snoozing_r, set_err_r;
  logic             tick_s, match_s, load_ok_s, set_err_nx_s;

  sec_tick_detect u_tick (
    .clk     (clk),
    .reset   (reset),
    .seconds (seconds),
    .tick    (tick_s)
  );

  // The registered alarm time is compared, so a same-cycle load cannot affect this match.
  assign match_s = tick_s && (minutes == alarm_min_r) && (seconds == alarm_sec_r);

  // Next-state, counter and load-acceptance decisions.
  always_comb begin
    state_nx_s    = state_r;
    ring_cnt_nx_s = ring_cnt_r;
    snz_cnt_nx_s  = snz_cnt_r;
    snz_used_nx_s = snz_used_r;

    load_ok_s    = set_valid && ((state_r == IDLE) || (state_r == ARMED)) &&
                   time_valid(set_min, set_sec);
    set_err_nx_s = set_valid && !load_ok_s;

    if (!arm_en) begin
      state_nx_s    = IDLE;
      ring_cnt_nx_s = 6'd0;
      snz_cnt_nx_s  = 6'd0;
      snz_used_nx_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s = ARMED;
        end
        ARMED: begin
          if (match_s) begin
            state_nx_s    = RINGING;
            ring_cnt_nx_s = 6'd0;
          end else begin
            state_nx_s = ARMED;
          end
        end
        RINGING: begin
          // A snooze press beyond the limit falls through as if not pressed.
          if (stop_btn) begin
            state_nx_s    = ARMED;
            snz_used_nx_s = '0;
          end else if (snooze_btn && (snz_used_r < SNZ_MAX)) begin
            state_nx_s    = SNOOZE;
            snz_used_nx_s = snz_used_r + SNZ_ONE;
            snz_cnt_nx_s  = 6'd0;
          end else if (tick_s && (ring_cnt_r == RING_LAST)) begin
            state_nx_s    = ARMED;
            snz_used_nx_s = '0;
          end else if (tick_s) begin
            ring_cnt_nx_s = ring_cnt_r + 6'd1;
          end else begin
            state_nx_s = RINGING;
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            state_nx_s    = ARMED;
            snz_used_nx_s = '0;
          end else if (tick_s && (snz_cnt_r == SNZ_LAST)) begin
            state_nx_s    = RINGING;
            ring_cnt_nx_s = 6'd0;
          end else if (tick_s) begin
            snz_cnt_nx_s = snz_cnt_r + 6'd1;
          end else begin
            state_nx_s = SNOOZE;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // State, counters, alarm time and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ring_cnt_r  <= 6'd0;
      snz_cnt_r   <= 6'd0;
      snz_used_r  <= '0;
      alarm_min_r <= 6'd0;
      alarm_sec_r <= 6'd0;
      ring_r      <= 1'b0;
      snoozing_r  <= 1'b0;
      set_err_r   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      ring_cnt_r <= ring_cnt_nx_s;
      snz_cnt_r  <= snz_cnt_nx_s;
      snz_used_r <= snz_used_nx_s;
      ring_r     <= (state_nx_s == RINGING);
      snoozing_r <= (state_nx_s == SNOOZE);
      set_err_r  <= set_err_nx_s;
      if (load_ok_s) begin
        alarm_min_r <= set_min;
        alarm_sec_r <= set_sec;
      end
    end
  end

  assign state     = state_r;
  assign ring      = ring_r;
  assign snoozing  = snoozing_r;
  assign alarm_min = alarm_min_r;
  assign alarm_sec = alarm_sec_r;
  assign set_err   = set_err_r;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller with default parameters.
module tb_alarm_controller;
  import clock_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [5:0]   seconds = 6'd0;
  logic [5:0]   minutes = 6'd0;
  logic         arm_en = 1'b0;
  logic         set_valid = 1'b0;
  logic [5:0]   set_min = 6'd0;
  logic [5:0]   set_sec = 6'd0;
  logic         snooze_btn = 1'b0;
  logic         stop_btn = 1'b0;
  logic         ring, snoozing, set_err;
  alarm_state_t state;
  logic [5:0]   alarm_min, alarm_sec;

  int errors = 0;
  int checks = 0;

  alarm_controller #(.RING_SECS(10), .SNOOZE_SECS(5), .MAX_SNOOZES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .seconds    (seconds),
    .minutes    (minutes),
    .arm_en     (arm_en),
    .set_valid  (set_valid),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .ring       (ring),
    .snoozing   (snoozing),
    .state      (state),
    .alarm_min  (alarm_min),
    .alarm_sec  (alarm_sec),
    .set_err    (set_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_time(input logic [5:0] m, input logic [5:0] s);
    minutes = m;
    seconds = s;
    cyc();
  endtask

  // One clock-counter step: exactly one tick.
  task automatic adv();
    if (seconds == 6'd59) begin
      seconds = 6'd0;
      minutes = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
    end else begin
      seconds = seconds + 6'd1;
    end
    cyc();
  endtask

  initial begin
    // Reset state
    cyc();
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_ring", 32'(ring), 32'd0);
    chk("rst_snoozing", 32'(snoozing), 32'd0);
    chk("rst_amin", 32'(alarm_min), 32'd0);
    chk("rst_asec", 32'(alarm_sec), 32'd0);
    chk("rst_seterr", 32'(set_err), 32'd0);

    // Load 01:05 and arm
    set_valid = 1'b1; set_min = 6'd1; set_sec = 6'd5;
    cyc();
    set_valid = 1'b0;
    chk("load_amin", 32'(alarm_min), 32'd1);
    chk("load_asec", 32'(alarm_sec), 32'd5);
    chk("load_seterr", 32'(set_err), 32'd0);
    arm_en = 1'b1;
    cyc();
    chk("arm_state", 32'(state), 32'(ARMED));

    // Match and ring duration
    set_time(6'd1, 6'd3);
    adv();
    chk("pre_match_ring", 32'(ring), 32'd0);
    adv();
    chk("match_ring", 32'(ring), 32'd1);
    chk("match_state", 32'(state), 32'(RINGING));
    for (int i = 0; i < 9; i++) adv();
    chk("ring_9ticks", 32'(ring), 32'd1);
    adv();
    chk("ring_timeout_ring", 32'(ring), 32'd0);
    chk("ring_timeout_state", 32'(state), 32'(ARMED));

    // Rejected load: seconds out of range
    set_valid = 1'b1; set_min = 6'd2; set_sec = 6'd60;
    cyc();
    set_valid = 1'b0;
    chk("bad_load_err", 32'(set_err), 32'd1);
    chk("bad_load_asec", 32'(alarm_sec), 32'd5);
    chk("bad_load_amin", 32'(alarm_min), 32'd1);
    cyc();
    chk("bad_load_err_pulse", 32'(set_err), 32'd0);

    // Ring again; a valid load while ringing is rejected
    set_time(6'd1, 6'd4);
    set_time(6'd1, 6'd5);
    chk("ring2", 32'(ring), 32'd1);
    set_valid = 1'b1; set_min = 6'd0; set_sec = 6'd10;
    cyc();
    set_valid = 1'b0;
    chk("ring_load_err", 32'(set_err), 32'd1);
    chk("ring_load_asec", 32'(alarm_sec), 32'd5);

    // Snooze #1: five ticks then back to ringing
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    chk("snz1_snoozing", 32'(snoozing), 32'd1);
    chk("snz1_ring", 32'(ring), 32'd0);
    for (int i = 0; i < 4; i++) adv();
    chk("snz1_4ticks", 32'(state), 32'(SNOOZE));
    adv();
    chk("snz1_rering", 32'(state), 32'(RINGING));
    chk("snz1_rering_ring", 32'(ring), 32'd1);

    // Snooze #2 accepted
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    chk("snz2_state", 32'(state), 32'(SNOOZE));
    for (int i = 0; i < 5; i++) adv();
    chk("snz2_rering", 32'(state), 32'(RINGING));

    // Snooze #3 ignored
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    chk("snz3_ignored_ring", 32'(ring), 32'd1);
    chk("snz3_ignored_state", 32'(state), 32'(RINGING));

    // Stop and snooze together: stop wins
    stop_btn = 1'b1; snooze_btn = 1'b1;
    cyc();
    stop_btn = 1'b0; snooze_btn = 1'b0;
    chk("stop_snz_state", 32'(state), 32'(ARMED));
    chk("stop_snz_snoozing", 32'(snoozing), 32'd0);
    chk("stop_snz_ring", 32'(ring), 32'd0);

    // Snooze count was cleared: a fresh ring accepts snooze
    set_time(6'd1, 6'd4);
    set_time(6'd1, 6'd5);
    chk("ring3", 32'(ring), 32'd1);
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    chk("snz_after_clear", 32'(state), 32'(SNOOZE));

    // Disarm from snooze
    arm_en = 1'b0;
    cyc();
    chk("disarm_state", 32'(state), 32'(IDLE));
    chk("disarm_snoozing", 32'(snoozing), 32'd0);
    set_time(6'd1, 6'd4);
    set_time(6'd1, 6'd5);
    chk("disarm_no_ring", 32'(ring), 32'd0);
    chk("disarm_idle", 32'(state), 32'(IDLE));

    // Reset mid-ring
    arm_en = 1'b1;
    cyc();
    chk("rearm_state", 32'(state), 32'(ARMED));
    set_time(6'd1, 6'd4);
    set_time(6'd1, 6'd5);
    chk("ring4", 32'(ring), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midring_rst_ring", 32'(ring), 32'd0);
    chk("midring_rst_state", 32'(state), 32'(IDLE));
    chk("midring_rst_amin", 32'(alarm_min), 32'd0);
    chk("midring_rst_asec", 32'(alarm_sec), 32'd0);
    cyc();
    chk("post_rst_armed", 32'(state), 32'(ARMED));

    // Free-run through 00:00 with the default alarm time
    set_time(6'd59, 6'd58);
    adv();
    chk("pre_wrap_ring", 32'(ring), 32'd0);
    adv();
    chk("wrap_ring", 32'(ring), 32'd1);
    chk("wrap_state", 32'(state), 32'(RINGING));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
